// File: rtl/serial_crc_pkg.sv
// rtl/serial_crc_pkg.sv - widths, mode encodings and init values for the serial CRC
package serial_crc_pkg;

    localparam int CRC_W  = 16;
    localparam int CRC8_W = 8;

    localparam logic MODE_CRC8  = 1'b0;
    localparam logic MODE_CRC16 = 1'b1;

    localparam logic [CRC_W-1:0] INIT_ZERO   = 16'h0000;
    localparam logic [CRC_W-1:0] INIT_ONES16 = 16'hFFFF;
    localparam logic [CRC_W-1:0] INIT_ONES8  = 16'h00FF;

endpackage

// File: rtl/serial_crc_step.sv
// rtl/serial_crc_step.sv - combinational one-bit MSB-first CRC update for CRC-8/CRC-16
module serial_crc_step
    import serial_crc_pkg::*;
(
    input  logic [CRC_W-1:0] i_crc,
    input  logic             i_bit,
    input  logic [CRC_W-1:0] i_poly,
    input  logic             i_mode,
    output logic [CRC_W-1:0] o_crc
);

    logic              w_fb16;
    logic              w_fb8;
    logic [CRC_W-1:0]  w_next16;
    logic [CRC8_W-1:0] w_next8;

    assign w_fb16   = i_crc[CRC_W-1] ^ i_bit;
    assign w_fb8    = i_crc[CRC8_W-1] ^ i_bit;
    assign w_next16 = {i_crc[CRC_W-2:0], 1'b0} ^ (w_fb16 ? i_poly : {CRC_W{1'b0}});
    assign w_next8  = {i_crc[CRC8_W-2:0], 1'b0} ^ (w_fb8 ? i_poly[CRC8_W-1:0] : {CRC8_W{1'b0}});

    // CRC-8 clears the upper byte so a later switch to CRC-16 starts clean
    assign o_crc = (i_mode == MODE_CRC16) ? w_next16 : {{(CRC_W-CRC8_W){1'b0}}, w_next8};

endmodule

// File: rtl/serial_crc.sv
// rtl/serial_crc.sv - serial CRC-8/CRC-16 engine; SERIAL_CRC_INIT_ONES_EN selects all-ones init
module serial_crc
    import serial_crc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             init,
    input  logic             crc_mode,
    input  logic [CRC_W-1:0] polynomial,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_next;
    logic [CRC_W-1:0] w_init;

`ifdef SERIAL_CRC_INIT_ONES_EN
    assign w_init = (crc_mode == MODE_CRC16) ? INIT_ONES16 : INIT_ONES8;
`else
    assign w_init = INIT_ZERO;
`endif

    serial_crc_step u_step (
        .i_crc  (r_crc),
        .i_bit  (data_in),
        .i_poly (polynomial),
        .i_mode (crc_mode),
        .o_crc  (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= w_init;
        end else if (init) begin
            r_crc <= w_init;
        end else if (data_valid) begin
            r_crc <= w_next;
        end
    end

    assign crc_out = (crc_mode == MODE_CRC16) ? r_crc : {{(CRC_W-CRC8_W){1'b0}}, r_crc[CRC8_W-1:0]};

endmodule

// File: tb/tb_serial_crc.sv
// tb/tb_serial_crc.sv - scoreboard bench for serial_crc against a polynomial-division model
module tb_serial_crc;

    logic        clk;
    logic        rst;
    logic        data_in;
    logic        data_valid;
    logic        init;
    logic        crc_mode;
    logic [15:0] polynomial;
    logic [15:0] crc_out;

`ifdef SERIAL_CRC_INIT_ONES_EN
    localparam logic [15:0] INIT16 = 16'hFFFF;
    localparam logic [15:0] INIT8  = 16'h00FF;
`else
    localparam logic [15:0] INIT16 = 16'h0000;
    localparam logic [15:0] INIT8  = 16'h0000;
`endif

    serial_crc dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .init       (init),
        .crc_mode   (crc_mode),
        .polynomial (polynomial),
        .crc_out    (crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        msg_q[$];
    logic        mdl_mode;
    logic [15:0] mdl_poly;
    logic [15:0] mdl_init;

    // remainder of (init * x^n + M(x) * x^w) divided by (x^w + poly), by long division
    function automatic logic [15:0] crc_ref(input logic mode, input logic [15:0] poly,
                                            input logic [15:0] ival, input logic m[$]);
        int          w;
        int          n;
        logic        d[];
        logic [15:0] r;
        w = mode ? 16 : 8;
        n = m.size();
        d = new[n + w];
        for (int i = 0; i < n + w; i++) d[i] = (i < n) ? m[i] : 1'b0;
        for (int j = 0; j < w; j++) d[j] = d[j] ^ ival[w-1-j];
        for (int i = 0; i < n; i++) begin
            if (d[i]) begin
                for (int j = 0; j < w; j++) d[i+1+j] = d[i+1+j] ^ poly[w-1-j];
                d[i] = 1'b0;
            end
        end
        r = 16'h0000;
        for (int j = 0; j < w; j++) r[w-1-j] = d[n+j];
        return r;
    endfunction

    function automatic logic [15:0] init_for(input logic mode);
        return mode ? INIT16 : INIT8;
    endfunction

    task automatic check_now(input logic [15:0] got, input logic [15:0] exp, input string tag);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock of stimulus; the model's view after the coming edge goes on the scoreboard
    task automatic step(input logic dv, input logic din, input logic ini, input logic rs);
        @(negedge clk);
        data_valid = dv;
        data_in    = din;
        init       = ini;
        rst        = rs;
        if (rs || ini) begin
            msg_q.delete();
            mdl_mode = crc_mode;
            mdl_poly = polynomial;
            mdl_init = init_for(crc_mode);
        end else if (dv) begin
            msg_q.push_back(din);
        end
        exp_q.push_back(crc_ref(mdl_mode, mdl_poly, mdl_init, msg_q));
        tag_q.push_back("model");
    endtask

    task automatic expect_now(input logic [15:0] val, input string tag);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    task automatic begin_msg(input logic mode, input logic [15:0] poly);
        @(negedge clk);
        crc_mode   = mode;
        polynomial = poly;
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic feed_bits(input logic [63:0] word, input int nbits, input int max_gap);
        for (int i = nbits - 1; i >= 0; i--) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0, 1'b0);
            step(1'b1, word[i], 1'b0, 1'b0);
        end
    endtask

    task automatic feed_check_string(input int max_gap);
        for (int c = 8'h31; c <= 8'h39; c++) feed_bits(64'(c), 8, max_gap);
    endtask

    always begin
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            logic [15:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            if (crc_out !== e) begin
                n_fail++;
                $display("FAIL %s: crc_out=%h expected=%h at %0t", t, crc_out, e, $time);
            end
        end
    end

    initial begin : watchdog
        #5000000;
        n_fail++;
        $display("FAIL timeout: test did not finish by %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic ref_bits[$];
        logic [63:0] w64;

        rst = 1'b0; init = 1'b0; data_valid = 1'b0; data_in = 1'b0;
        crc_mode = 1'b1; polynomial = 16'h8005;
        mdl_mode = 1'b1; mdl_poly = 16'h8005; mdl_init = INIT16;

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        expect_now(INIT16, "reset_value");
        @(posedge clk);
        #2;
        check_now(crc_out, INIT16, "reset_direct");
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_now(INIT16, "init_after_reset");

`ifndef SERIAL_CRC_INIT_ONES_EN
        begin_msg(1'b0, 16'h0007);
        feed_bits(64'h01, 8, 0);
        expect_now(16'h0007, "crc8_byte01");
        begin_msg(1'b1, 16'h8005);
        feed_bits(64'h01, 8, 0);
        expect_now(16'h8005, "crc16_byte01");
        begin_msg(1'b0, 16'h0007);
        feed_check_string(0);
        expect_now(16'h00F4, "crc8_check");
        begin_msg(1'b1, 16'h8005);
        feed_check_string(0);
        expect_now(16'hFEE8, "crc16_check");
        begin_msg(1'b0, 16'h0007);
        feed_check_string(3);
        expect_now(16'h00F4, "crc8_check_gaps");
`else
        begin_msg(1'b0, 16'h0007);
        feed_bits(64'h00, 8, 0);
        expect_now(16'h00F3, "crc8_ones_zero_byte");
        begin_msg(1'b1, 16'h8005);
        feed_check_string(0);
        expect_now(16'hAEE7, "crc16_ones_check");
        begin_msg(1'b0, 16'h0007);
        feed_check_string(3);
        expect_now(crc_ref(1'b0, 16'h0007, INIT8, msg_q), "crc8_ones_gaps");
`endif

        begin_msg(1'b1, 16'h1021);
        feed_bits(64'h2D, 6, 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        expect_now(INIT16, "init_over_valid");
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_now(INIT16, "init_bit_not_consumed");
        feed_bits(64'hA5, 8, 0);

        feed_bits(64'h3C, 8, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        expect_now(INIT16, "reset_mid_message");
        feed_bits(64'h5A, 8, 1);

        begin_msg(1'b1, 16'h8005);
        feed_bits(64'h11223344, 32, 0);
        feed_bits(64'h55667788, 32, 2);
        w64 = 64'h1122334455667788;
        ref_bits.delete();
        for (int i = 63; i >= 0; i--) ref_bits.push_back(w64[i]);
        expect_now(crc_ref(1'b1, 16'h8005, INIT16, ref_bits), "crc16_continuous_64");

        for (int k = 0; k < 24; k++) begin
            int len;
            begin_msg(1'($urandom), 16'($urandom));
            len = int'($urandom_range(1, 48));
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom), 1'b0, 1'b0);
                if ($urandom_range(0, 29) == 0) step(1'b1, 1'($urandom), 1'b1, 1'b0);
                else step(1'b1, 1'($urandom), 1'b0, 1'b0);
            end
        end

        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_now(16'(exp_q.size()), 16'h0000, "scoreboard_drained");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_crc.md
SERIAL_CRC -- requirements
Module: serial_crc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port data_in, input, 1 bit: serial message bit, MSB of each byte first.
REQ-005 Port data_valid, input, 1 bit: data_in is consumed on each rising edge where this is high.
REQ-006 Port init, input, 1 bit: synchronous CRC register re-initialisation.
REQ-007 Port crc_mode, input, 1 bit: 0 selects CRC-8, 1 selects CRC-16.
REQ-008 Port polynomial, input, 16 bits: generator polynomial, implicit top term; only bits [7:0] are used in CRC-8 mode.
REQ-009 Port crc_out, output, 16 bits: current CRC value.

Function
REQ-010 The block SHALL hold a 16-bit register crc_q.
- Non-reflected CRC, MSB-first.
- No final XOR.
REQ-011 CRC-16 step, when data_valid=1 and init=0: fb = crc_q[15]^data_in; crc_q <= {crc_q[14:0],1'b0} ^ (fb ? polynomial : 16'h0000).
REQ-012 CRC-8 step, when data_valid=1 and init=0: fb = crc_q[7]^data_in; crc_q[7:0] <= {crc_q[6:0],1'b0} ^ (fb ? polynomial[7:0] : 8'h00); crc_q[15:8] <= 8'h00.
REQ-013 Exactly one bit SHALL be consumed per clock with data_valid=1.
- No bit is consumed when data_valid=0.
- crc_q holds its value when data_valid=0.
REQ-014 When init=1, crc_q SHALL load INIT_VAL and data_in is ignored that cycle, even if data_valid=1.
REQ-015 INIT_VAL SHALL be 16'h0000, or as set by REQ-020.
REQ-016 crc_out SHALL be crc_q when crc_mode=1, and {8'h00, crc_q[7:0]} when crc_mode=0.
- crc_out is a combinational mask of the register.
- Latency: the effect of a bit appears on crc_out one clock after the edge that consumes it.
REQ-017 crc_mode and polynomial SHALL be sampled on every consuming edge.
- A change mid-message takes effect on the next consumed bit.
- No other side effect occurs.

Reset
REQ-018 On rst=1 at a rising edge, crc_q SHALL load INIT_VAL.
REQ-019 Priority SHALL be rst > init > data_valid.
- Reset in mid-message discards all accumulated state.
- crc_out after reset is 16'h0000, or 16'hFFFF when SERIAL_CRC_INIT_ONES_EN is defined (CRC-8 mode shows 16'h00FF).

Configuration
REQ-020 Macro SERIAL_CRC_INIT_ONES_EN selects the initial value.
- Defined: INIT_VAL is 16'hFFFF in CRC-16 mode and 16'h00FF in CRC-8 mode, based on crc_mode at the init/reset edge.
- Undefined: INIT_VAL is 16'h0000.

Structure
REQ-021 Package serial_crc_pkg SHALL hold:
- Constants CRC_W=16 and CRC8_W=8.
- Mode constants MODE_CRC8=1'b0 and MODE_CRC16=1'b1.
- INIT value constants.
REQ-022 The combinational one-bit update SHALL be a sub-module serial_crc_step.
- Inputs: crc, bit, poly, mode.
- Output: next crc.
- The top instantiates it once and owns only the register, priority logic and output mask.

Verification
REQ-023 Reset: assert rst 2 cycles, macro off -> crc_out=16'h0000; init pulse -> still 16'h0000.
REQ-024 Single bit: CRC-8, poly 16'h0007, init, then byte 8'h01 over 8 valid cycles -> crc_out=16'h0007; CRC-16, poly 16'h8005, same byte -> 16'h8005.
REQ-025 Standard check: ASCII "123456789" (8'h31..8'h39, 72 valid cycles):
- CRC-8, poly 16'h0007 -> 16'h00F4.
- CRC-16, poly 16'h8005 -> 16'hFEE8.
REQ-026 Gaps and priority:
- Repeat REQ-025 CRC-8 with data_valid deasserted for random 0-3 cycles between bits -> 16'h00F4.
- Assert init together with data_valid=1 mid-message -> register 16'h0000 next cycle, bit not consumed.
- Assert rst mid-message -> crc_out 16'h0000 next cycle.
REQ-027 Macro defined:
- CRC-8, poly 16'h0007, init, 8 zero bits -> 16'h00F3.
- CRC-16, poly 16'h8005, init, "123456789" -> 16'hAEE7.
REQ-028 Continuous message, CRC-16: 32'h11223344 then 32'h55667788 without init -> equal to a single 64-bit feed of 64'h1122334455667788, compared against a software reference model.
